// File: rtl/wptr_full_if.sv
// Write-side FIFO pointer bus: write request/status signals shared between
// the write client (master) and the pointer/full controller (slave).
interface wptr_full_if #(
  parameter int PTR_WIDTH = 5
);
  logic                 wr_en_i;
  logic                 wr_ovf_clr_i;
  logic [PTR_WIDTH:0]   rptr_gray_i;
  logic                 wr_full_o;
  logic                 wr_afull_o;
  logic [PTR_WIDTH-1:0] wr_addr_o;
  logic [PTR_WIDTH:0]   wptr_gray_o;
  logic [PTR_WIDTH:0]   wptr_bin_o;
  logic [PTR_WIDTH:0]   wr_level_o;
  logic                 wr_ovf_o;

  modport master (
    output wr_en_i, wr_ovf_clr_i, rptr_gray_i,
    input  wr_full_o, wr_afull_o, wr_addr_o, wptr_gray_o, wptr_bin_o,
           wr_level_o, wr_ovf_o
  );

  modport slave (
    input  wr_en_i, wr_ovf_clr_i, rptr_gray_i,
    output wr_full_o, wr_afull_o, wr_addr_o, wptr_gray_o, wptr_bin_o,
           wr_level_o, wr_ovf_o
  );
endinterface

// File: rtl/wptr_full.sv
// Async FIFO write-domain controller: binary/Gray write pointers, RAM write
// address, and full/almost-full/level/overflow derived from the synced read pointer.
module wptr_full #(
  parameter int PTR_WIDTH    = 5,
  parameter int AFULL_THRESH = 28
) (
  input logic        wr_clk_i,
  input logic        rstn_i,
  wptr_full_if.slave bus
);

  localparam int AW = PTR_WIDTH + 1;

  function automatic logic [AW-1:0] bin2gray(input logic [AW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
    logic [AW-1:0] b;
    b[AW-1] = g[AW-1];
    for (int i = AW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW-1:0] wbin_q, wbin_d;
  logic [AW-1:0] wgray_q, wgray_d;
  logic [AW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] rbin;
  logic [AW-1:0] rgray_full;
  logic          wr_inc;

  always_comb begin
    wr_inc     = bus.wr_en_i & ~full_q;
    wbin_d     = wbin_q + AW'(wr_inc);
    wgray_d    = bin2gray(wbin_d);
    rbin       = gray2bin(bus.rptr_gray_i);
    // Full when the write pointer is exactly one lap ahead: in Gray code
    // that flips the top two bits of the read pointer.
    rgray_full = {~bus.rptr_gray_i[AW-1:AW-2], bus.rptr_gray_i[AW-3:0]};
    full_d     = (wgray_d == rgray_full);
    level_d    = wbin_d - rbin;
    afull_d    = (level_d >= AW'(AFULL_THRESH));
    ovf_d      = (bus.wr_en_i & full_q) | (ovf_q & ~bus.wr_ovf_clr_i);
  end

  always_ff @(posedge wr_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.wr_full_o   = full_q;
  assign bus.wr_afull_o  = afull_q;
  assign bus.wr_addr_o   = wbin_q[PTR_WIDTH-1:0];
  assign bus.wptr_gray_o = wgray_q;
  assign bus.wptr_bin_o  = wbin_q;
  assign bus.wr_level_o  = level_q;
  assign bus.wr_ovf_o    = ovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: table of input/expected-output vectors plus
// hand-written sequences for asynchronous reset behaviour.
module tb_wptr_full;

  localparam int PW = 5;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  wptr_full_if #(.PTR_WIDTH(PW)) wif ();

  wptr_full #(.PTR_WIDTH(PW), .AFULL_THRESH(28)) dut (
    .wr_clk_i (clk),
    .rstn_i   (rstn),
    .bus      (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       wr_en;
    logic       clr;
    logic [5:0] rptr;
    logic       full;
    logic       afull;
    logic       ovf;
    logic [5:0] bin;
    logic [5:0] gray;
    logic [5:0] level;
    logic [4:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] g(input int b);
    logic [5:0] x;
    x = 6'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic void add(input string nm, input logic we, input logic cl,
                              input logic [5:0] rp, input logic fu, input logic af,
                              input logic ov, input int bn, input int lv);
    vec_t v;
    v.name  = nm;
    v.wr_en = we;
    v.clr   = cl;
    v.rptr  = rp;
    v.full  = fu;
    v.afull = af;
    v.ovf   = ov;
    v.bin   = 6'(bn);
    v.gray  = g(bn);
    v.level = 6'(lv);
    v.addr  = 5'(bn);
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic check_outs(input string nm, input int idx, input vec_t v);
    check({nm, ".full"},  idx, int'(wif.wr_full_o),   int'(v.full));
    check({nm, ".afull"}, idx, int'(wif.wr_afull_o),  int'(v.afull));
    check({nm, ".ovf"},   idx, int'(wif.wr_ovf_o),    int'(v.ovf));
    check({nm, ".bin"},   idx, int'(wif.wptr_bin_o),  int'(v.bin));
    check({nm, ".gray"},  idx, int'(wif.wptr_gray_o), int'(v.gray));
    check({nm, ".level"}, idx, int'(wif.wr_level_o),  int'(v.level));
    check({nm, ".addr"},  idx, int'(wif.wr_addr_o),   int'(v.addr));
  endtask

  task automatic check_zero(input string nm);
    vec_t z;
    z.name = nm; z.wr_en = 0; z.clr = 0; z.rptr = '0;
    z.full = 0; z.afull = 0; z.ovf = 0;
    z.bin = '0; z.gray = '0; z.level = '0; z.addr = '0;
    check_outs(nm, 0, z);
  endtask

  logic [5:0] prev_gray;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Idle after reset
    for (int i = 0; i < 10; i++) add("idle", 0, 0, 6'd0, 0, 0, 0, 0, 0);
    // Fill 32 words with the read side parked at 0
    for (int k = 1; k <= 32; k++) add("fill", 1, 0, 6'd0, k == 32, k >= 28, 0, k, k);
    // Overflow attempts at full
    for (int i = 0; i < 3; i++) add("ovf", 1, 0, 6'd0, 1, 1, 1, 32, 32);
    add("ovf_clr",      0, 1, 6'd0, 1, 1, 0, 32, 32);
    add("ovf_set_wins", 1, 1, 6'd0, 1, 1, 1, 32, 32);
    add("ovf_clr2",     0, 1, 6'd0, 1, 1, 0, 32, 32);
    // Read side catches up completely
    add("drain", 0, 0, 6'b110000, 0, 0, 0, 32, 0);
    // Second lap: binary pointer wraps to 0 on the 32nd write
    for (int k = 1; k <= 32; k++)
      add("wrap", 1, 0, 6'b110000, k == 32, k >= 28, 0, (32 + k) % 64, k);
    // One read to level 31, then write+read together, then a lone write
    add("read1",      0, 0, 6'b110001, 0, 1, 0, 0, 31);
    add("wr_and_rd",  1, 0, 6'b110011, 0, 1, 0, 1, 31);
    add("fill_again", 1, 0, 6'b110011, 1, 1, 0, 2, 32);

    wif.wr_en_i      = 1'b0;
    wif.wr_ovf_clr_i = 1'b0;
    wif.rptr_gray_i  = '0;
    rstn             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #4 rstn = 1'b1;

    prev_gray = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      wif.wr_en_i      = vecs[i].wr_en;
      wif.wr_ovf_clr_i = vecs[i].clr;
      wif.rptr_gray_i  = vecs[i].rptr;
      @(posedge clk);
      #1;
      check_outs(vecs[i].name, i, vecs[i]);
      check("gray_1bit", i, int'($countones(prev_gray ^ wif.wptr_gray_o) <= 1), 1);
      prev_gray = wif.wptr_gray_o;
    end

    // Async reset from a full state, between edges
    wif.wr_en_i      = 1'b0;
    wif.wr_ovf_clr_i = 1'b0;
    #2 rstn = 1'b0;
    #1 check_zero("async_rst_full");
    wif.rptr_gray_i = '0;
    @(posedge clk);
    #3 rstn = 1'b1;

    // Reset mid-fill after 10 writes
    wif.wr_en_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midfill.bin", 0, int'(wif.wptr_bin_o), 10);
    check("midfill.level", 0, int'(wif.wr_level_o), 10);
    wif.wr_en_i = 1'b0;
    #1 rstn = 1'b0;
    #1 check_zero("async_rst_midfill");
    #1 rstn = 1'b1;
    #1 check("post_rst.addr", 0, int'(wif.wr_addr_o), 0);
    wif.wr_en_i = 1'b1;
    @(posedge clk);
    #1;
    wif.wr_en_i = 1'b0;
    check("post_rst.bin", 0, int'(wif.wptr_bin_o), 1);
    check("post_rst.addr1", 0, int'(wif.wr_addr_o), 1);
    check("post_rst.level", 0, int'(wif.wr_level_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag controller for the asynchronous FIFO; the counterpart of the read-pointer/empty block. It runs entirely in the write clock domain. It advances the binary and Gray write pointers on accepted writes and generates the memory write address. From the read Gray pointer, already synchronised into this domain, it derives full, almost-full, fill level and a sticky overflow flag.

## Interface
- PTR_WIDTH, 5, address width; FIFO depth = 2^PTR_WIDTH; legal range ≥ 2
- AFULL_THRESH, 28, almost-full threshold in words; legal range 1..2^PTR_WIDTH

Ports:
- wr_clk_i  in  1  write clock; all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- wr_en_i  in  1  write request
- wr_ovf_clr_i  in  1  clears sticky overflow
- rptr_gray_i  in  PTR_WIDTH+1  read Gray pointer, already 2-flop synchronised into wr_clk_i (sync lives outside this block)
- wr_full_o  out  1  FIFO full (registered)
- wr_afull_o  out  1  level ≥ AFULL_THRESH (registered)
- wr_addr_o  out  PTR_WIDTH  RAM write address for the current cycle
- wptr_gray_o  out  PTR_WIDTH+1  write Gray pointer, to the read-domain synchroniser
- wptr_bin_o  out  PTR_WIDTH+1  write binary pointer
- wr_level_o  out  PTR_WIDTH+1  words in FIFO as seen from the write side, 0..2^PTR_WIDTH
- wr_ovf_o  out  1  sticky: write attempted while full

## Operation
- Accept: wr_inc = wr_en_i & ~wr_full_o.
  - The RAM writes at wr_addr_o in any cycle where wr_inc = 1.
- Next binary pointer: wbin_nxt = wptr_bin_o + wr_inc, modulo 2^(PTR_WIDTH+1). The counter wraps naturally; the MSB is the lap bit.
- Next Gray pointer: wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1).
- Next address: wr_addr_nxt = wbin_nxt[PTR_WIDTH-1:0].
  - wr_addr_o always equals wptr_bin_o[PTR_WIDTH-1:0].
- Read pointer decode: rbin = Gray-to-binary(rptr_gray_i), combinational, with bit i = XOR of rptr_gray_i[PTR_WIDTH:i].
- Full, next: wgray_nxt == {~rptr_gray_i[PTR_WIDTH:PTR_WIDTH-1], rptr_gray_i[PTR_WIDTH-2:0]}.
- Level, next: wbin_nxt − rbin, modulo 2^(PTR_WIDTH+1); the result is always ≤ 2^PTR_WIDTH.
- Almost-full, next: level_nxt ≥ AFULL_THRESH (unsigned compare).
- Invariant: wr_full_o == (wr_level_o == 2^PTR_WIDTH) on every cycle.
- Full and level are pessimistic because the read pointer lags by the synchroniser delay.
  - The block never reports not-full while the FIFO is full.
  - It may report full for a few cycles after a read.
- Overflow:
  - Set: wr_en_i & wr_full_o.
  - Clear: wr_ovf_clr_i.
  - Set wins over a simultaneous clear.
  - An overflowing write does not advance any pointer.
- Reset values:
  - wptr_bin_o, wptr_gray_o, wr_addr_o, wr_level_o = 0
  - wr_full_o = 0, wr_afull_o = 0, wr_ovf_o = 0

## Timing
- Every output is a flop; there are no combinational paths from inputs to outputs.
- Write at edge N (wr_inc = 1 sampled): pointers, address, level, full and afull reflect it after edge N.
- A filling write is the one that takes the level to 2^PTR_WIDTH.
  - wr_full_o rises at the same edge that commits it.
  - Back-to-back writes never overrun.
- A change in rptr_gray_i reaches wr_full_o, wr_level_o and wr_afull_o one edge later, with no further latency inside the block.
- Write and read-pointer change in the same cycle: both are folded into the same next-state computation, so the level moves by (+1 − reads).
- wptr_gray_o changes at most one bit per edge, which makes it CDC-safe.
- Async reset asserted mid-operation:
  - All outputs go to reset values immediately, without a clock edge.
  - The read side must be reset together with this block.
  - Release is synchronised externally.

## Test plan
- Reset, then idle with rptr_gray_i = 0:
  - All outputs 0 and full = 0.
  - After reset release with wr_en_i = 0 for 10 cycles, nothing changes.
- Fill (PTR_WIDTH = 5, rptr_gray_i = 0, wr_en_i = 1 for 32 cycles):
  - wr_addr_o steps 0..31.
  - afull rises after the 28th write, when level = 28.
  - After the 32nd write: full = 1, wptr_bin_o = 32, wptr_gray_o = 6'b110000, level = 32.
- Overflow: hold wr_en_i for 3 more cycles at full.
  - Pointers stay at 32 and wr_ovf_o = 1.
  - Pulse wr_ovf_clr_i: wr_ovf_o = 0 next cycle.
  - Clear together with an overflowing write: wr_ovf_o stays 1.
- Drain and wrap:
  - Drive rptr_gray_i = 6'b110000: full = 0 and level = 0 next cycle.
  - Write 32 more: wptr_bin_o wraps to 0, wptr_gray_o = 0, full = 1.
- Simultaneous events at level 31:
  - One write while rptr_gray_i advances by one: level stays 31, full stays 0.
  - A write with no read change: full = 1.
- Reset mid-fill: assert rstn_i low after 10 writes, between clock edges.
  - All outputs drop to 0 immediately.
  - After release, the first write goes to address 0.
